// File: rtl/vga_pkg.sv
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared constants, state encoding and the cell-address helper for
//           the VGA cell frame buffer arbiter.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int H_TOTAL   = 800;
    localparam int V_TOTAL   = 521;
    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int CELL_COLS = 160;
    localparam int CELL_ROWS = 120;
    localparam int FB_DEPTH  = 19200;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // row*160 + col as row*128 + row*32 + col; keeps multipliers out of the
    // address path.
    function automatic logic [14:0] cell_addr(input logic [6:0] row,
                                              input logic [7:0] col);
        logic [14:0] r;
        r = {8'd0, row};
        return (r << 7) + (r << 5) + {7'd0, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_fetch_sched.sv
// ============================================================================
// Module  : vga_fetch_sched
// Purpose : Combinational display-prefetch slot detector. Flags the cycles in
//           which the frame RAM must be read for the display and produces the
//           cell address to read.
// Ports   : start_i    - display enable
//           pixel_x_i  - horizontal count
//           pixel_y_i  - vertical count
//           rd_en_o    - this cycle is a display read slot
//           rd_addr_o  - cell address for the display read
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fetch_sched #(
    parameter int H_TOTAL  = vga_pkg::H_TOTAL,
    parameter int V_TOTAL  = vga_pkg::V_TOTAL,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int ADDR_W   = 15
) (
    input  logic              start_i,
    input  logic [9:0]        pixel_x_i,
    input  logic [9:0]        pixel_y_i,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o
);

    logic [9:0] w_ny;
    logic [6:0] w_row;
    logic [7:0] w_col;

    always_comb begin
        rd_en_o = 1'b0;
        w_row   = 7'd0;
        w_col   = 8'd0;
        w_ny    = (pixel_y_i == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_y_i + 10'd1;
        if (start_i) begin
            // x = 4k+2, k = 0..158: fetch the cell that starts at x = 4k+4.
            if ((pixel_x_i[1:0] == 2'd2) && (pixel_x_i < 10'(H_ACTIVE - 4)) &&
                (pixel_y_i < 10'(V_ACTIVE))) begin
                rd_en_o = 1'b1;
                w_row   = pixel_y_i[8:2];
                w_col   = pixel_x_i[9:2] + 8'd1;
            end else if ((pixel_x_i == 10'(H_TOTAL - 1)) &&
                         (w_ny < 10'(V_ACTIVE))) begin
                // Last cycle of the line: column 0 of the upcoming line.
                rd_en_o = 1'b1;
                w_row   = w_ny[8:2];
                w_col   = 8'd0;
            end
        end
    end

    assign rd_addr_o = ADDR_W'(vga_pkg::cell_addr(w_row, w_col));

endmodule

`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
// ============================================================================
// Module  : vga_fb_arbiter
// Purpose : Single-port cell frame RAM arbiter. Display prefetch reads take
//           fixed slots, a background clear runs on request, and drawing
//           writes use every remaining cycle. Drives the current pixel colour.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           start_i, blank_i    - display enable, visible-region flag
//           pixel_x_i/pixel_y_i - timing generator counts
//           wr_req_i/addr/data  - drawing write request, wr_ack_o accept
//           clr_req_i/clr_color - frame clear request, busy_o, clr_done_o
//           ram_*               - frame RAM interface
//           color_out_o         - colour for the current pixel
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fb_arbiter #(
    parameter int H_TOTAL   = 800,
    parameter int V_TOTAL   = 521,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int CELL_COLS = 160,
    parameter int CELL_ROWS = 120,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [9:0]        pixel_x_i,
    input  logic [9:0]        pixel_y_i,
    input  logic              blank_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ack_o,
    input  logic              clr_req_i,
    input  logic [DATA_W-1:0] clr_color_i,
    output logic              busy_o,
    output logic              clr_done_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [DATA_W-1:0] color_out_o
);

    import vga_pkg::state_t;
    import vga_pkg::IDLE;
    import vga_pkg::CLEAR;

    localparam int          FB_CELLS = CELL_COLS * CELL_ROWS;
    localparam [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_CELLS);
    localparam [ADDR_W-1:0] FB_LAST  = ADDR_W'(FB_CELLS - 1);

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [DATA_W-1:0]   clr_color_q;
    logic [DATA_W-1:0]   cur_cell_q;
    logic                disp_rd_q;
    logic                busy_q;
    logic                clr_done_q;

    logic                w_slot_rd;
    logic [ADDR_W-1:0]   w_slot_addr;
    logic                w_clr_wr;

    vga_fetch_sched #(
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .ADDR_W   (ADDR_W)
    ) u_sched (
        .start_i   (start_i),
        .pixel_x_i (pixel_x_i),
        .pixel_y_i (pixel_y_i),
        .rd_en_o   (w_slot_rd),
        .rd_addr_o (w_slot_addr)
    );

    // Port arbitration: display slot > clear > drawing write. RAM strobes are
    // held low while rst is asserted so a reset cycle never commits a write.
    always_comb begin
        wr_ack_o    = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        w_clr_wr    = 1'b0;
        if (!rst) begin
            if (w_slot_rd) begin
                ram_en_o   = 1'b1;
                ram_addr_o = w_slot_addr;
            end else if (state_q == CLEAR) begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = clr_cnt_q;
                ram_wdata_o = clr_color_q;
                w_clr_wr    = 1'b1;
            end else if (wr_req_i) begin
                // Out-of-range writes are acknowledged but dropped.
                wr_ack_o = 1'b1;
                if (wr_addr_i < FB_LIMIT) begin
                    ram_en_o    = 1'b1;
                    ram_we_o    = 1'b1;
                    ram_addr_o  = wr_addr_i;
                    ram_wdata_o = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            cur_cell_q  <= '0;
            disp_rd_q   <= 1'b0;
            busy_q      <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            // Read data is valid the cycle after the slot; capture it then.
            disp_rd_q  <= w_slot_rd;
            if (disp_rd_q) begin
                cur_cell_q <= ram_rdata_i;
            end
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_req_i) begin
                        state_q     <= CLEAR;
                        busy_q      <= 1'b1;
                        clr_color_q <= clr_color_i;
                        clr_cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    if (w_clr_wr) begin
                        if (clr_cnt_q == FB_LAST) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            clr_done_q <= 1'b1;
                            clr_cnt_q  <= '0;
                        end else begin
                            clr_cnt_q <= clr_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign clr_done_o  = clr_done_q;
    assign color_out_o = (start_i && blank_i) ? cur_cell_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
// ============================================================================
// Module  : tb_vga_fb_arbiter
// Purpose : Directed self-checking bench for vga_fb_arbiter with a behavioural
//           single-port frame RAM.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [9:0]  pixel_x_i;
    logic [9:0]  pixel_y_i;
    logic        blank_i;
    logic        wr_req_i;
    logic [14:0] wr_addr_i;
    logic [7:0]  wr_data_i;
    logic        wr_ack_o;
    logic        clr_req_i;
    logic [7:0]  clr_color_i;
    logic        busy_o;
    logic        clr_done_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [14:0] ram_addr_o;
    logic [7:0]  ram_wdata_o;
    logic [7:0]  ram_rdata;
    logic [7:0]  color_out_o;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [0:19199];
    int         wr_count = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .pixel_x_i   (pixel_x_i),
        .pixel_y_i   (pixel_y_i),
        .blank_i     (blank_i),
        .wr_req_i    (wr_req_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .wr_ack_o    (wr_ack_o),
        .clr_req_i   (clr_req_i),
        .clr_color_i (clr_color_i),
        .busy_o      (busy_o),
        .clr_done_o  (clr_done_o),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata),
        .color_out_o (color_out_o)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                if (ram_addr_o < 15'd19200) mem[ram_addr_o] <= ram_wdata_o;
                wr_count <= wr_count + 1;
            end else if (ram_addr_o < 15'd19200) begin
                ram_rdata <= mem[ram_addr_o];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic write_cell(input logic [14:0] a, input logic [7:0] d);
        start_i   = 1'b0;
        wr_req_i  = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        #2;
        n_vec++;
        if (wr_ack_o !== 1'b1) begin
            n_err++;
            $display("FAIL preload_ack addr %0d: got %b expected 1", a, wr_ack_o);
        end
        tick();
        wr_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; blank_i = 1'b0; wr_req_i = 1'b0;
        wr_addr_i = '0; wr_data_i = '0; clr_req_i = 1'b0; clr_color_i = '0;
        pixel_x_i = 10'd100; pixel_y_i = 10'd0;
        repeat (3) tick();
        rst = 1'b0; start_i = 1'b1; blank_i = 1'b1;
        #2;
        n_vec++;
        if ({wr_ack_o, busy_o, clr_done_o, ram_en_o, ram_we_o} !== 5'b0 ||
            color_out_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: got ack/busy/done/en/we=%b color=%h expected 00000 color=00",
                     {wr_ack_o, busy_o, clr_done_o, ram_en_o, ram_we_o}, color_out_o);
        end
        tick();
    endtask

    task automatic test_display_line();
        write_cell(15'd1, 8'h3C);
        write_cell(15'd2, 8'h55);
        start_i = 1'b1; blank_i = 1'b1; pixel_y_i = 10'd0;
        for (int x = 0; x < 10; x++) begin
            pixel_x_i = 10'(x);
            #2;
            if (x == 2) begin
                n_vec++;
                if (ram_en_o !== 1'b1 || ram_we_o !== 1'b0 || ram_addr_o !== 15'd1) begin
                    n_err++;
                    $display("FAIL slot_x2: got en=%b we=%b addr=%0d expected en=1 we=0 addr=1",
                             ram_en_o, ram_we_o, ram_addr_o);
                end
            end
            if (x == 3) chk("no_slot_x3_en", int'(ram_en_o), 0);
            if (x == 6) chk("slot_x6_addr", int'(ram_addr_o), 2);
            if (x >= 4 && x <= 7) chk("color_cell1", int'(color_out_o), 'h3C);
            if (x >= 8) chk("color_cell2", int'(color_out_o), 'h55);
            tick();
        end
        blank_i = 1'b0;
        #2;
        chk("color_blanked", int'(color_out_o), 0);
        tick();
    endtask

    task automatic test_slot_bounds();
        write_cell(15'd160, 8'h99);
        write_cell(15'd0, 8'h44);
        start_i = 1'b1; blank_i = 1'b1; pixel_y_i = 10'd0;
        pixel_x_i = 10'd634; #2;
        chk("slot_x634_addr", int'(ram_addr_o), 159);
        tick();
        pixel_x_i = 10'd638; #2;
        chk("no_slot_x638_en", int'(ram_en_o), 0);
        tick();
        pixel_x_i = 10'd799; pixel_y_i = 10'd3; #2;
        chk("slot_x799_y3_en", int'(ram_en_o), 1);
        chk("slot_x799_y3_addr", int'(ram_addr_o), 160);
        tick();
        pixel_x_i = 10'd0; pixel_y_i = 10'd4;
        tick();
        pixel_x_i = 10'd1; #2;
        chk("color_row1_col0", int'(color_out_o), 'h99);
        tick();
        pixel_x_i = 10'd799; pixel_y_i = 10'd479; #2;
        chk("no_slot_x799_y479", int'(ram_en_o), 0);
        tick();
        pixel_x_i = 10'd799; pixel_y_i = 10'd520; #2;
        chk("slot_x799_y520_en", int'(ram_en_o), 1);
        chk("slot_x799_y520_addr", int'(ram_addr_o), 0);
        tick();
        pixel_x_i = 10'd0; pixel_y_i = 10'd0;
        tick();
        pixel_x_i = 10'd1; #2;
        chk("color_wrap_cell0", int'(color_out_o), 'h44);
        tick();
    endtask

    task automatic test_write_slot();
        int wc;
        start_i = 1'b1; blank_i = 1'b0; pixel_y_i = 10'd0;
        wr_req_i = 1'b1; wr_addr_i = 15'd5; wr_data_i = 8'hA1;
        pixel_x_i = 10'd2;
        wc = wr_count;
        #2;
        chk("wr_blocked_by_slot_ack", int'(wr_ack_o), 0);
        chk("wr_blocked_by_slot_we", int'(ram_we_o), 0);
        tick();
        pixel_x_i = 10'd3; #2;
        n_vec++;
        if (wr_ack_o !== 1'b1 || ram_we_o !== 1'b1 || ram_addr_o !== 15'd5 ||
            ram_wdata_o !== 8'hA1) begin
            n_err++;
            $display("FAIL wr_grant_x3: got ack=%b we=%b addr=%0d data=%h expected 1 1 5 a1",
                     wr_ack_o, ram_we_o, ram_addr_o, ram_wdata_o);
        end
        tick();
        wr_req_i = 1'b0; pixel_x_i = 10'd4;
        tick();
        chk("wr_mem5", int'(mem[5]), 'hA1);
        chk("wr_single_commit", wr_count - wc, 1);
    endtask

    task automatic test_write_oob();
        start_i = 1'b0;
        wr_req_i = 1'b1; wr_addr_i = 15'd19200; wr_data_i = 8'hEE;
        #2;
        chk("oob_ack", int'(wr_ack_o), 1);
        chk("oob_ram_en", int'(ram_en_o), 0);
        tick();
        wr_req_i = 1'b0;
    endtask

    task automatic test_clear();
        int busy_cnt = 0, rd_busy = 0, ack_bad = 0, done_cnt = 0, post = 0, bad = 0;
        bit seen = 0;
        int x = 0, y = 0;
        start_i = 1'b1; blank_i = 1'b1;
        pixel_x_i = 10'd0; pixel_y_i = 10'd0;
        clr_req_i = 1'b1; clr_color_i = 8'h07; wr_req_i = 1'b0;
        tick();
        clr_req_i = 1'b0; clr_color_i = 8'hFF;
        wr_req_i = 1'b1; wr_addr_i = 15'd10; wr_data_i = 8'h07;
        for (int c = 0; c < 40000; c++) begin
            x++;
            if (x == 800) begin
                x = 0;
                y = (y == 520) ? 0 : y + 1;
            end
            pixel_x_i = 10'(x); pixel_y_i = 10'(y);
            #2;
            if (busy_o) begin
                busy_cnt++;
                if (ram_en_o && !ram_we_o) rd_busy++;
                if (wr_ack_o) ack_bad++;
            end
            if (clr_done_o) begin
                done_cnt++;
                seen = 1;
            end
            tick();
            if (seen) post++;
            if (post == 5) break;
        end
        wr_req_i = 1'b0;
        chk("clr_done_seen", int'(seen), 1);
        chk("clr_done_count", done_cnt, 1);
        chk("clr_no_wr_ack", ack_bad, 0);
        chk("clr_busy_cycles", busy_cnt, 19200 + rd_busy);
        for (int i = 0; i < 19200; i++) if (mem[i] !== 8'h07) bad++;
        chk("clr_mem_bad_cells", bad, 0);
    endtask

    task automatic test_rst_mid_clear();
        bit found = 0;
        int done_seen = 0;
        start_i = 1'b0; blank_i = 1'b1;
        pixel_x_i = 10'd2; pixel_y_i = 10'd0;
        clr_req_i = 1'b1; clr_color_i = 8'h11;
        wr_req_i = 1'b1; wr_addr_i = 15'd19000; wr_data_i = 8'h22;
        #2;
        chk("clr_wr_same_cycle_ack", int'(wr_ack_o), 1);
        tick();
        clr_req_i = 1'b0; wr_req_i = 1'b0;
        #2;
        chk("clr_busy_next", int'(busy_o), 1);
        for (int c = 0; c < 300; c++) begin
            if (ram_we_o && ram_addr_o == 15'd100) begin
                found = 1;
                break;
            end
            tick();
            #2;
        end
        chk("rst_counter_100_reached", int'(found), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rst_busy_cleared", int'(busy_o), 0);
        chk("rst_ram_en_idle", int'(ram_en_o), 0);
        for (int c = 0; c < 5; c++) begin
            if (clr_done_o) done_seen++;
            tick();
            #2;
        end
        chk("rst_no_clr_done", done_seen, 0);
        chk("partial_mem50", int'(mem[50]), 'h11);
        chk("partial_mem100", int'(mem[100]), 'h07);
        chk("partial_mem19000", int'(mem[19000]), 'h22);
        pixel_x_i = 10'd2; pixel_y_i = 10'd0; start_i = 1'b0; blank_i = 1'b1;
        #1;
        chk("nostart_no_read", int'(ram_en_o), 0);
        chk("nostart_color0", int'(color_out_o), 0);
        wr_req_i = 1'b1; wr_addr_i = 15'd30; wr_data_i = 8'h5A;
        #1;
        chk("rst_idle_grants_write", int'(wr_ack_o), 1);
        tick();
        wr_req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_display_line();
        test_slot_bounds();
        test_write_slot();
        test_write_oob();
        test_clear();
        test_rst_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
